// File: rtl/uart_pkg.sv
// Shared UART definitions: default frame/baud parameters and the one-hot
// receiver state encoding, used by uart_rx, uart_tx and uart_rx_interface.
package uart_pkg;

    localparam int NB_DATA_DEF  = 8;
    localparam int N_TICKS_DEF  = 16;
    localparam int BAUD_DIV_DEF = 163;

    typedef enum logic [4:0] {
        ST_IDLE   = 5'b00001,
        ST_START  = 5'b00010,
        ST_DATA   = 5'b00100,
        ST_PARITY = 5'b01000,
        ST_STOP   = 5'b10000
    } rxState_e;

endpackage

// File: rtl/baud_rate_gen.sv
// Free-running oversampling tick generator: counts 0..BAUD_DIV-1 and emits a
// one-cycle tick on the last count. Shared by the UART receiver and transmitter.
module baud_rate_gen
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = BAUD_DIV_DEF
) (
    input  logic i_clock,
    input  logic i_reset,
    output logic o_tick
);

    localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(BAUD_DIV - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Wrap back to zero after the last count, otherwise advance by one.
    always_comb begin
        count_d = (count_q == LAST) ? '0 : count_q + 1'b1;
    end

    // Divider register.
    always_ff @(posedge i_clock) begin
        if (i_reset) count_q <= '0;
        else         count_q <= count_d;
    end

    assign o_tick = (count_q == LAST);

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronised input, oversampled start/data/stop
// detection with a one-hot FSM, registered valid and frame-error pulses.
// Optional even-parity bit is enabled by defining UART_RX_PARITY_EN, which
// adds the PARITY state and the o_parity_error port.
module uart_rx
    import uart_pkg::*;
#(
    parameter int NB_DATA  = NB_DATA_DEF,
    parameter int N_TICKS  = N_TICKS_DEF,
    parameter int BAUD_DIV = BAUD_DIV_DEF
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_rx,
    output logic [NB_DATA-1:0] o_rx_data,
    output logic               o_rx_data_valid,
    output logic               o_frame_error,
    output logic               o_busy
`ifdef UART_RX_PARITY_EN
    ,
    output logic               o_parity_error
`endif
);

    localparam int NB = $clog2(N_TICKS);
    localparam int BW = $clog2(NB_DATA + 1);
    localparam logic [NB-1:0] HALF_LAST = NB'(N_TICKS / 2 - 1);
    localparam logic [NB-1:0] FULL_LAST = NB'(N_TICKS - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(NB_DATA - 1);

    logic               tick;
    logic               rxSync1_q;
    logic               rxSync2_q;
    logic               rxIn;
    rxState_e           state_q,     state_d;
    logic [NB-1:0]      sampleCnt_q, sampleCnt_d;
    logic [BW-1:0]      bitCnt_q,    bitCnt_d;
    logic [NB_DATA-1:0] shift_q,     shift_d;
    logic [NB_DATA-1:0] rxData_q,    rxData_d;
    logic               valid_q,     valid_d;
    logic               frameErr_q,  frameErr_d;
`ifdef UART_RX_PARITY_EN
    logic               parityBit_q, parityBit_d;
    logic               parityErr_q, parityErr_d;
`endif

    baud_rate_gen #(.BAUD_DIV(BAUD_DIV)) uBaudGen (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .o_tick  (tick)
    );

    // Two-flop synchroniser on the asynchronous line; idles high out of reset.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            rxSync1_q <= 1'b1;
            rxSync2_q <= 1'b1;
        end else begin
            rxSync1_q <= i_rx;
            rxSync2_q <= rxSync1_q;
        end
    end

    assign rxIn = rxSync2_q;

    // Next-state logic: sample mid start bit, then once per bit period.
    always_comb begin
        state_d     = state_q;
        sampleCnt_d = sampleCnt_q;
        bitCnt_d    = bitCnt_q;
        shift_d     = shift_q;
        rxData_d    = rxData_q;
        valid_d     = 1'b0;
        frameErr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
        parityBit_d = parityBit_q;
        parityErr_d = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (!rxIn) begin
                    state_d     = ST_START;
                    sampleCnt_d = '0;
                end
            end
            ST_START: begin
                if (tick) begin
                    if (sampleCnt_q == HALF_LAST) begin
                        if (!rxIn) begin
                            state_d     = ST_DATA;
                            sampleCnt_d = '0;
                            bitCnt_d    = '0;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        sampleCnt_d = sampleCnt_q + 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (tick) begin
                    if (sampleCnt_q == FULL_LAST) begin
                        shift_d     = {rxIn, shift_q[NB_DATA-1:1]};
                        sampleCnt_d = '0;
                        bitCnt_d    = bitCnt_q + 1'b1;
                        if (bitCnt_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                            state_d = ST_PARITY;
`else
                            state_d = ST_STOP;
`endif
                        end
                    end else begin
                        sampleCnt_d = sampleCnt_q + 1'b1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (tick) begin
                    if (sampleCnt_q == FULL_LAST) begin
                        parityBit_d = rxIn;
                        sampleCnt_d = '0;
                        state_d     = ST_STOP;
                    end else begin
                        sampleCnt_d = sampleCnt_q + 1'b1;
                    end
                end
            end
`endif
            ST_STOP: begin
                if (tick) begin
                    if (sampleCnt_q == FULL_LAST) begin
                        state_d = ST_IDLE;
                        if (!rxIn) begin
                            frameErr_d = 1'b1;
`ifdef UART_RX_PARITY_EN
                        end else if ((^shift_q) != parityBit_q) begin
                            parityErr_d = 1'b1;
`endif
                        end else begin
                            rxData_d = shift_q;
                            valid_d  = 1'b1;
                        end
                    end else begin
                        sampleCnt_d = sampleCnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, counters, shift register and registered output pulses.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q     <= ST_IDLE;
            sampleCnt_q <= '0;
            bitCnt_q    <= '0;
            shift_q     <= '0;
            rxData_q    <= '0;
            valid_q     <= 1'b0;
            frameErr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parityBit_q <= 1'b0;
            parityErr_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            sampleCnt_q <= sampleCnt_d;
            bitCnt_q    <= bitCnt_d;
            shift_q     <= shift_d;
            rxData_q    <= rxData_d;
            valid_q     <= valid_d;
            frameErr_q  <= frameErr_d;
`ifdef UART_RX_PARITY_EN
            parityBit_q <= parityBit_d;
            parityErr_q <= parityErr_d;
`endif
        end
    end

    assign o_rx_data       = rxData_q;
    assign o_rx_data_valid = valid_q;
    assign o_frame_error   = frameErr_q;
    assign o_busy          = (state_q != ST_IDLE);
`ifdef UART_RX_PARITY_EN
    assign o_parity_error  = parityErr_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: serial frames are driven bit by bit, the
// expected receiver event for each frame is queued when the frame starts and
// compared when the DUT pulses valid / frame error (/ parity error).
`timescale 1ns/1ps
module tb_uart_rx;

    localparam int NB_DATA  = 8;
    localparam int N_TICKS  = 16;
    localparam int BAUD_DIV = 4;
    localparam int BIT_CLKS = N_TICKS * BAUD_DIV;

    localparam int EV_VALID  = 1;
    localparam int EV_FRAME  = 2;
    localparam int EV_PARITY = 3;

    typedef struct {
        int           kind;
        logic [7:0]   data;
    } expEvent_t;

    logic               i_clock = 1'b0;
    logic               i_reset = 1'b1;
    logic               i_rx    = 1'b1;
    logic [NB_DATA-1:0] o_rx_data;
    logic               o_rx_data_valid;
    logic               o_frame_error;
    logic               o_busy;
    logic               parErr;

    expEvent_t  expQ[$];
    expEvent_t  ev;
    int         obsKind;
    int         totalChecks = 0;
    int         badChecks   = 0;
    logic [7:0] heldData    = 8'h00;

`ifdef UART_RX_PARITY_EN
    logic o_parity_error;
    assign parErr = o_parity_error;
`else
    assign parErr = 1'b0;
`endif

    uart_rx #(
        .NB_DATA  (NB_DATA),
        .N_TICKS  (N_TICKS),
        .BAUD_DIV (BAUD_DIV)
    ) dut (
        .i_clock         (i_clock),
        .i_reset         (i_reset),
        .i_rx            (i_rx),
        .o_rx_data       (o_rx_data),
        .o_rx_data_valid (o_rx_data_valid),
        .o_frame_error   (o_frame_error),
        .o_busy          (o_busy)
`ifdef UART_RX_PARITY_EN
        ,
        .o_parity_error  (o_parity_error)
`endif
    );

    always #5 i_clock = ~i_clock;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        totalChecks++;
        if (got !== exp) begin
            badChecks++;
            $display("[TB] FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic waitClocks(input int n);
        repeat (n) @(negedge i_clock);
    endtask

    // Drive one frame LSB first; the expected DUT event is queued up front.
    task automatic applyStimulus(input logic [7:0] data, input bit stopVal, input bit badParity);
        expEvent_t e;
        if (!stopVal) begin
            e.kind = EV_FRAME;
            e.data = heldData;
`ifdef UART_RX_PARITY_EN
        end else if (badParity) begin
            e.kind = EV_PARITY;
            e.data = heldData;
`endif
        end else begin
            e.kind   = EV_VALID;
            e.data   = data;
            heldData = data;
        end
        expQ.push_back(e);
        i_rx = 1'b0;
        waitClocks(BIT_CLKS);
        for (int i = 0; i < NB_DATA; i++) begin
            i_rx = data[i];
            waitClocks(BIT_CLKS);
        end
`ifdef UART_RX_PARITY_EN
        i_rx = (^data) ^ badParity;
        waitClocks(BIT_CLKS);
`endif
        if (stopVal) begin
            i_rx = 1'b1;
            waitClocks(BIT_CLKS);
        end else begin
            i_rx = 1'b0;
            waitClocks(BIT_CLKS * 10 / 16);
            i_rx = 1'b1;
            waitClocks(BIT_CLKS);
        end
    endtask

    // Scoreboard monitor: every output pulse pops and checks one expectation.
    always @(negedge i_clock) begin
        if (!i_reset && (o_rx_data_valid || o_frame_error || parErr)) begin
            obsKind = o_rx_data_valid ? EV_VALID : (o_frame_error ? EV_FRAME : EV_PARITY);
            checkOutput("exclusive", {30'd0, o_rx_data_valid & o_frame_error, o_rx_data_valid & parErr}, 32'd0);
            if (expQ.size() == 0) begin
                checkOutput("unexpected_event", obsKind, 0);
            end else begin
                ev = expQ.pop_front();
                checkOutput("event_kind", obsKind, ev.kind);
                checkOutput("event_data", {24'd0, o_rx_data}, {24'd0, ev.data});
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        waitClocks(5);
        checkOutput("reset_data",  {24'd0, o_rx_data}, 32'd0);
        checkOutput("reset_valid", {31'd0, o_rx_data_valid}, 32'd0);
        checkOutput("reset_ferr",  {31'd0, o_frame_error}, 32'd0);
        checkOutput("reset_busy",  {31'd0, o_busy}, 32'd0);
        i_reset = 1'b0;
        waitClocks(BIT_CLKS);

        applyStimulus(8'h5A, 1'b1, 1'b0);
        applyStimulus(8'hC3, 1'b0, 1'b0);

        // Short low glitch must be rejected at the start-bit midpoint.
        i_rx = 1'b0;
        waitClocks(2 * BAUD_DIV);
        checkOutput("glitch_busy_high", {31'd0, o_busy}, 32'd1);
        waitClocks(2 * BAUD_DIV);
        i_rx = 1'b1;
        waitClocks(12 * BAUD_DIV);
        checkOutput("glitch_busy_low", {31'd0, o_busy}, 32'd0);
        checkOutput("hold_data", {24'd0, o_rx_data}, {24'd0, heldData});

        applyStimulus(8'h01, 1'b1, 1'b0);
        applyStimulus(8'hFF, 1'b1, 1'b0);
        waitClocks(BIT_CLKS);

        // Reset in the middle of the data bits of 0x3C aborts the frame.
        i_rx = 1'b0;
        waitClocks(BIT_CLKS);
        for (int i = 0; i < 3; i++) begin
            i_rx = (8'h3C >> i) & 1'b1;
            waitClocks(BIT_CLKS);
        end
        i_rx = 1'b1;
        waitClocks(BIT_CLKS / 2);
        i_reset = 1'b1;
        waitClocks(3);
        i_reset = 1'b0;
        heldData = 8'h00;
        waitClocks(1);
        checkOutput("abort_busy", {31'd0, o_busy}, 32'd0);
        checkOutput("abort_data", {24'd0, o_rx_data}, 32'd0);
        waitClocks(BIT_CLKS);
        applyStimulus(8'hA5, 1'b1, 1'b0);
`ifdef UART_RX_PARITY_EN
        applyStimulus(8'h07, 1'b1, 1'b1);
`endif

        for (int i = 0; i < 4 * BIT_CLKS && expQ.size() > 0; i++) waitClocks(1);
        checkOutput("queue_drained", expQ.size(), 0);
        checkOutput("final_busy", {31'd0, o_busy}, 32'd0);
        checkOutput("final_data", {24'd0, o_rx_data}, {24'd0, heldData});

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The module SHALL have parameter NB_DATA, default 8, data bits per frame.
REQ-002 The module SHALL have parameter N_TICKS, default 16, oversampling ticks per bit.
REQ-003 The module SHALL have parameter BAUD_DIV, default 163, clock cycles per oversampling tick (50 MHz, 19200 baud x16).
REQ-004 Port i_clock  input  1  system clock; all logic on rising edge.
REQ-005 Port i_reset  input  1  reset, synchronous, active-high.
REQ-006 Port i_rx  input  1  asynchronous serial line, idle high.
REQ-007 Port o_rx_data  output  NB_DATA  last correctly received byte.
REQ-008 Port o_rx_data_valid  output  1  one-cycle pulse, o_rx_data updated.
REQ-009 Port o_frame_error  output  1  one-cycle pulse, stop bit sampled low.
REQ-010 Port o_busy  output  1  high in any state other than IDLE.

Function
REQ-011 i_rx SHALL pass through a 2-flop synchronizer before use; both flops reset to 1.
REQ-012 A free-running tick counter SHALL count 0..BAUD_DIV-1 and assert an internal one-cycle tick at BAUD_DIV-1.
REQ-013 The FSM SHALL have states IDLE, START, DATA, STOP (plus PARITY, see Configuration), one-hot encoded.
REQ-014 IDLE: synchronized rx==0 -> START, sample counter cleared to 0.
REQ-015 START: on tick with sample counter == N_TICKS/2-1, rx==0 -> DATA (counter and bit counter cleared); rx==1 -> IDLE (glitch rejected, no output).
REQ-016 DATA: on tick with sample counter == N_TICKS-1, rx SHALL be shifted into shift register LSB first, counter cleared, bit counter incremented; after NB_DATA bits -> STOP.
REQ-017 STOP: on tick with sample counter == N_TICKS-1, rx==1 -> o_rx_data <= shift register and o_rx_data_valid pulses next cycle; rx==0 -> o_frame_error pulses, o_rx_data unchanged; both cases -> IDLE.
REQ-018 Sample counter SHALL increment only on ticks and SHALL be NB = clog2(N_TICKS) bits, wrapping never exercised (cleared on each bit boundary).
REQ-019 o_rx_data_valid and o_frame_error SHALL never be asserted in the same cycle.
REQ-020 o_rx_data SHALL hold its value between valid pulses.
REQ-021 A new start bit SHALL be accepted in the first IDLE cycle after STOP (back-to-back frames supported).
REQ-022 Unreachable FSM encodings SHALL return to IDLE next cycle.

Reset
REQ-023 On i_reset: state IDLE, all counters 0, shift register 0, o_rx_data 0, o_rx_data_valid 0, o_frame_error 0, o_busy 0, synchronizer 1.
REQ-024 Reset mid-frame SHALL abort the frame with no valid or error pulse; reception resumes at the next falling edge after reset release.

Configuration
REQ-025 Macro UART_RX_PARITY_EN defined: a PARITY state SHALL follow DATA, sampling one even-parity bit; mismatch SHALL suppress o_rx_data_valid and pulse output o_parity_error (1 bit, reset 0) at the STOP decision cycle.
REQ-026 Macro undefined: no PARITY state, no o_parity_error port, DATA -> STOP directly.

Structure
REQ-027 Shared package uart_pkg SHALL hold NB_DATA, N_TICKS, BAUD_DIV defaults and the state encoding constants, shared with uart_tx and uart_rx_interface.
REQ-028 The tick generator SHALL be a sub-module baud_rate_gen (ports i_clock, i_reset, o_tick), reused by uart_tx.

Verification
REQ-029 Frame 0x5A, stop=1, at 16x BAUD_DIV ticks/bit -> exactly one o_rx_data_valid pulse, o_rx_data==0x5A, o_frame_error stays 0.
REQ-030 Frame 0xC3 with stop bit driven 0 -> one o_frame_error pulse, no valid pulse, o_rx_data keeps previous 0x5A.
REQ-031 Low glitch of 4 ticks on idle line -> FSM returns to IDLE, no valid/error pulse, o_busy high only during glitch window.
REQ-032 Back-to-back frames 0x01 then 0xFF with no idle gap -> two valid pulses, data 0x01 then 0xFF.
REQ-033 i_reset asserted mid-DATA of 0x3C, then frame 0xA5 -> no pulse for 0x3C, single valid with 0xA5.
REQ-034 With UART_RX_PARITY_EN, frame 0x07 with parity bit 0 (wrong; even parity requires 1) -> o_parity_error pulse, no valid pulse.
